// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs 24-bit RGB pixels, 4 pixels into 3 words, onto a 32-bit AXI4-Stream with tuser/tlast framing.
// Optional in_sof frame resync is enabled by defining PACKER_RESYNC_EN.
module pixel_stream_packer #(
  parameter int X_PIXELS = 640,
  parameter int Y_SIZE   = 480
) (
  input  logic        out_stream_aclk,
  input  logic        axi_resetn,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
`ifdef PACKER_RESYNC_EN
  input  logic        in_sof,
`endif
  output logic        in_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        out_stream_tuser,
  output logic        out_stream_tlast,
  output logic        frame_done
);
  localparam int WORDS = X_PIXELS * 3 / 4;
  localparam int XW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int YW = Y_SIZE > 1 ? $clog2(Y_SIZE) : 1;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  phase_t phase_q, phase_d;
  logic [23:0] residue_q, residue_d, pix;
  logic [XW-1:0] word_x_q, word_x_d;
  logic [YW-1:0] line_y_q, line_y_d;
  logic [31:0] tdata_q, tdata_d, word;
  logic tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic flast_q, flast_d, frame_done_q, frame_done_d;
  logic accept, hs, sof, load, x_end, y_end;
  assign in_ready = (phase_q == PH0) | ~tvalid_q | out_stream_tready;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tdata  = tdata_q;
  assign out_stream_tvalid = tvalid_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tlast  = tlast_q;
  assign frame_done        = frame_done_q;
  always_comb begin
    pix    = {in_r, in_g, in_b};
    accept = in_valid & in_ready;
    hs     = tvalid_q & out_stream_tready;
`ifdef PACKER_RESYNC_EN
    sof    = accept & in_sof;
`else
    sof    = 1'b0;
`endif
    // a resync pixel restarts packing as pixel 0 of a fresh frame
    load   = accept & ~sof & (phase_q != PH0);
    x_end  = word_x_q == XW'(WORDS - 1);
    y_end  = line_y_q == YW'(Y_SIZE - 1);
    phase_d = sof ? PH1 : accept ? phase_t'(phase_q + 2'd1) : phase_q;
    residue_d = ~accept ? residue_q :
                (sof | phase_q == PH0) ? pix :
                phase_q == PH1 ? {8'h0, pix[23:8]} :
                phase_q == PH2 ? {16'h0, pix[23:16]} : 24'h0;
    word = phase_q == PH1 ? {pix[7:0], residue_q} :
           phase_q == PH2 ? {pix[15:0], residue_q[15:0]} :
                            {pix, residue_q[7:0]};
    word_x_d = sof ? '0 : load ? (x_end ? '0 : word_x_q + XW'(1)) : word_x_q;
    line_y_d = sof ? '0 : (load & x_end) ? (y_end ? '0 : line_y_q + YW'(1)) : line_y_q;
    tvalid_d = load | (tvalid_q & ~out_stream_tready);
    tdata_d  = load ? word : tdata_q;
    tuser_d  = load ? (word_x_q == '0 && line_y_q == '0) : tuser_q;
    tlast_d  = load ? x_end : tlast_q;
    flast_d  = load ? (x_end & y_end) : flast_q;
    frame_done_d = hs & flast_q;
  end
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      phase_q      <= PH0;
      residue_q    <= '0;
      word_x_q     <= '0;
      line_y_q     <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      flast_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      residue_q    <= residue_d;
      word_x_q     <= word_x_d;
      line_y_q     <= line_y_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      flast_q      <= flast_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule
